decoder_scan_seq: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable.
- Adds an auto-scan mode that steps the active output through indices 0..last with a programmable dwell.
- Successor to the fixed 3/4-bit combinational decoders; intended for digit/row scanning and one-hot select generation.
- Sits between control logic and multiplexed output drivers.

---
 rtl/decoder_pkg.sv | 38 +++
 rtl/decoder_scan_seq_scan_counter.sv | 69 ++++++
 rtl/decoder_scan_seq.sv | 86 ++++++++
 tb/tb_decoder_scan_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings and helpers for the one-hot scan decoder.
package decoder_pkg;

   // Mode input encodings
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest one-hot vector the helper can build (select widths up to 8 bits)
   localparam int unsigned ONEHOT_MAX_N = 8;
   localparam int unsigned ONEHOT_MAX_W = 1 << ONEHOT_MAX_N;

   // Operating state, re-evaluated every cycle from enable/mode
   typedef enum logic [1:0] {
      OFF    = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;

   // Command from the top-level mode mux to the scan counter
   typedef enum logic [1:0] {
      CNT_HOLD    = 2'd0,
      CNT_LOAD    = 2'd1,
      CNT_RESTART = 2'd2,
      CNT_STEP    = 2'd3
   } cnt_op_e;

   // One-hot of idx within an n-bit select space; callers truncate to 2^n bits
   function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [ONEHOT_MAX_N-1:0] idx,
                                                      input int unsigned n);
      logic [ONEHOT_MAX_W-1:0] vec;
      vec = '0;
      if (32'(idx) < (32'd1 << n)) begin
         vec[idx] = 1'b1;
      end
      return vec;
   endfunction

endpackage : decoder_pkg

// File: rtl/decoder_scan_seq_scan_counter.sv
// Dwell counter plus index counter with inclusive last-compare and wrap flag.
module scan_counter
   import decoder_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  cnt_op_e            op,
   input  logic [N-1:0]       load_idx,
   input  logic [N-1:0]       last,
   input  logic [DWELL_W-1:0] dwell,
   output logic [N-1:0]       idx,
   output logic [N-1:0]       idx_nxt_c,
   output logic               wrap_nxt_c
);

   logic [N-1:0]       idx_q;
   logic [DWELL_W-1:0] cnt_q, cnt_d;

   // Next index/dwell count; the >= compare lets a lowered last wrap immediately
   always_comb begin
      idx_nxt_c  = idx_q;
      cnt_d      = cnt_q;
      wrap_nxt_c = 1'b0;
      unique case (op)
         CNT_HOLD: begin
         end
         CNT_LOAD: begin
            idx_nxt_c = load_idx;
            cnt_d     = '0;
         end
         CNT_RESTART: begin
            idx_nxt_c = '0;
            cnt_d     = '0;
         end
         CNT_STEP: begin
            if (cnt_q < dwell) begin
               cnt_d = cnt_q + DWELL_W'(1);
            end else begin
               cnt_d = '0;
               if (idx_q >= last) begin
                  idx_nxt_c  = '0;
                  wrap_nxt_c = 1'b1;
               end else begin
                  idx_nxt_c = idx_q + N'(1);
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_nxt_c;
         cnt_q <= cnt_d;
      end
   end

   assign idx = idx_q;

endmodule : scan_counter

// File: rtl/decoder_scan_seq.sv
// Registered N-to-2^N one-hot decoder with enable and auto-scan mode.
module decoder_scan_seq
   import decoder_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned DWELL_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                mode,
   input  logic [N-1:0]        in,
   input  logic [N-1:0]        last,
   input  logic [DWELL_W-1:0]  dwell,
   output logic [(2**N)-1:0]   out,
   output logic [N-1:0]        idx,
   output logic                valid,
   output logic                wrap
);

   localparam int unsigned OUT_W = 2**N;

   state_e            state_q, state_d;
   cnt_op_e           cnt_op;
   logic [N-1:0]      idx_nxt_c;
   logic              wrap_nxt_c;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              valid_q, valid_d;
   logic              wrap_q, wrap_d;

   scan_counter #(
      .N       (N),
      .DWELL_W (DWELL_W)
   ) u_scan_counter (
      .clk        (clk),
      .rst        (rst),
      .op         (cnt_op),
      .load_idx   (in),
      .last       (last),
      .dwell      (dwell),
      .idx        (idx),
      .idx_nxt_c  (idx_nxt_c),
      .wrap_nxt_c (wrap_nxt_c)
   );

   // State selection and mode mux; entering SCAN from any other state restarts at 0
   always_comb begin
      state_d = OFF;
      cnt_op  = CNT_HOLD;
      out_d   = '0;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      if (enable) begin
         valid_d = 1'b1;
         out_d   = OUT_W'(onehot(ONEHOT_MAX_N'(idx_nxt_c), N));
         if (mode == MODE_SCAN) begin
            state_d = SCAN;
            cnt_op  = (state_q == SCAN) ? CNT_STEP : CNT_RESTART;
            wrap_d  = wrap_nxt_c;
         end else begin
            state_d = DIRECT;
            cnt_op  = CNT_LOAD;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OFF;
         out_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign wrap  = wrap_q;

endmodule : decoder_scan_seq

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench: driver pushes model predictions, monitor compares each cycle.
module tb_decoder_scan_seq;

   localparam int unsigned N       = 4;
   localparam int unsigned DWELL_W = 8;
   localparam int unsigned OUT_W   = 2**N;

   logic               clk;
   logic               rst;
   logic               enable;
   logic               mode;
   logic [N-1:0]       in;
   logic [N-1:0]       last;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   out;
   logic [N-1:0]       idx;
   logic               valid;
   logic               wrap;

   typedef struct packed {
      logic [OUT_W-1:0] out;
      logic [N-1:0]     idx;
      logic             valid;
      logic             wrap;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: index, cycles already spent at that index, whether last cycle was scanning
   int   m_idx  = 0;
   int   m_held = 0;
   bit   m_scan = 0;

   decoder_scan_seq #(.N(N), .DWELL_W(DWELL_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .mode   (mode),
      .in     (in),
      .last   (last),
      .dwell  (dwell),
      .out    (out),
      .idx    (idx),
      .valid  (valid),
      .wrap   (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Report a failed condition
   task automatic check(input bit ok, input string what);
      if (!ok) begin
         n_err++;
         $display("FAIL t=%0t %s", $time, what);
      end
   endtask

   // Apply one cycle of inputs and push the predicted post-edge outputs
   task automatic step(input bit r, input bit e, input bit m, input int i, input int l, input int d);
      exp_t x;
      @(negedge clk);
      rst    = r;
      enable = e;
      mode   = m;
      in     = N'(i);
      last   = N'(l);
      dwell  = DWELL_W'(d);
      x.wrap = 1'b0;
      if (r) begin
         m_idx = 0; m_held = 0; m_scan = 0;
      end else if (!e) begin
         m_scan = 0;
      end else if (!m) begin
         m_idx = i; m_held = 0; m_scan = 0;
      end else if (!m_scan) begin
         m_idx = 0; m_held = 0; m_scan = 1;
      end else if (m_held < d) begin
         m_held++;
      end else begin
         m_held = 0;
         if (m_idx >= l) begin
            m_idx  = 0;
            x.wrap = 1'b1;
         end else begin
            m_idx++;
         end
      end
      x.idx   = N'(m_idx);
      x.valid = !r && e;
      x.out   = x.valid ? (OUT_W'(1) << m_idx) : '0;
      exp_q.push_back(x);
   endtask

   // Monitor: one registered result per clock, compared against the oldest prediction
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_vec++;
            if (out !== x.out || idx !== x.idx || valid !== x.valid || wrap !== x.wrap) begin
               n_err++;
               $display("FAIL vec%0d t=%0t got out=%h idx=%0d valid=%b wrap=%b want out=%h idx=%0d valid=%b wrap=%b",
                        n_vec, $time, out, idx, valid, wrap, x.out, x.idx, x.valid, x.wrap);
            end
         end
      end
   end

   initial begin
      int cur_l, cur_d;
      bit cur_m;
      rst = 1'b1; enable = 1'b0; mode = 1'b0; in = '0; last = '0; dwell = '0;

      // Reset then idle with enable low
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      check(out === '0 && idx === '0 && valid === 1'b0 && wrap === 1'b0,
            $sformatf("reset state out=%h idx=%0d valid=%b wrap=%b", out, idx, valid, wrap));
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0);

      // Direct sweep over every select value
      for (int k = 0; k < 16; k++) step(0, 1, 0, k, 0, 0);

      // Scan last=3 dwell=0
      for (int k = 0; k < 12; k++) step(0, 1, 1, 0, 3, 0);
      // Scan last=2 dwell=2 (restart via direct cycle)
      step(0, 1, 0, 7, 2, 2);
      for (int k = 0; k < 20; k++) step(0, 1, 1, 0, 2, 2);

      // Lower last below current index mid-scan
      step(0, 0, 1, 0, 7, 0);
      for (int k = 0; k < 40 && m_idx != 5; k++) step(0, 1, 1, 0, 7, 0);
      check(m_idx == 5, "wait for idx=5 expired");
      for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 2, 0);

      // Mode toggle restarts the scan; then drop enable
      step(0, 1, 0, 11, 2, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 5, 1);
      step(0, 0, 1, 0, 5, 1);
      step(0, 0, 1, 0, 5, 1);
      for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 5, 1);

      // Reset mid-scan at idx 6 with dwell 4, then resume
      step(0, 0, 1, 0, 9, 4);
      for (int k = 0; k < 80 && m_idx != 6; k++) step(0, 1, 1, 0, 9, 4);
      check(m_idx == 6, "wait for idx=6 expired");
      step(1, 1, 1, 0, 9, 4);
      for (int k = 0; k < 8; k++) step(0, 1, 1, 0, 9, 4);

      // Full range and maximal dwell
      step(0, 0, 1, 0, 15, 0);
      for (int k = 0; k < 34; k++) step(0, 1, 1, 0, 15, 0);
      for (int k = 0; k < 520; k++) step(0, 1, 1, 0, 1, 255);
      for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 0, 1);

      // Randomised traffic with slowly changing mode/last/dwell
      cur_m = 1; cur_l = 5; cur_d = 1;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 29) == 0) cur_m = ~cur_m;
         if ($urandom_range(0, 39) == 0) cur_l = int'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 3))
               0: cur_d = 0;
               1: cur_d = int'($urandom_range(1, 3));
               2: cur_d = int'($urandom_range(0, 255));
               default: cur_d = 255;
            endcase
         end
         step($urandom_range(0, 149) == 0, $urandom_range(0, 24) != 0, cur_m,
              int'($urandom_range(0, 15)), cur_l, cur_d);
      end

      step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check(exp_q.size() == 0, "scoreboard not drained");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      if (n_err == 0) $display("PASS");
      else            $display("FAIL");
      $finish;
   end

endmodule : tb_decoder_scan_seq
